riscv_lsu: RTL and testbench

- Load/store unit between the memory-stage pipeline and riscv_dm; drives every data-memory access.
- Naturally aligned accesses pass straight through in the request cycle.
- Misaligned accesses are split by an FSM into aligned doubleword reads and read-modify-write doublewords, stalling the pipeline.
- Produces sign- or zero-extended 64-bit load data for writeback.

---
 rtl/riscv_lsu.sv | 199 +++++++++++++++++++
 tb/tb_riscv_lsu.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit: aligned accesses pass straight to the data memory; misaligned
// ones are split into doubleword reads and read-modify-write doublewords.
module riscv_lsu #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        i_riscv_lsu_clk,
  input  logic        i_riscv_lsu_rst_n,
  input  logic        i_riscv_lsu_req,
  input  logic        i_riscv_lsu_we,
  input  logic [1:0]  i_riscv_lsu_size,
  input  logic        i_riscv_lsu_unsigned,
  input  logic [63:0] i_riscv_lsu_addr,
  input  logic [63:0] i_riscv_lsu_wdata,
  output logic        o_riscv_lsu_stall,
  output logic [63:0] o_riscv_lsu_rdata,
  output logic        o_riscv_lsu_rvalid,
  output logic        o_riscv_lsu_misaligned,
  output logic        o_riscv_lsu_dm_wen,
  output logic [1:0]  o_riscv_lsu_dm_sel,
  output logic [63:0] o_riscv_lsu_dm_addr,
  output logic [63:0] o_riscv_lsu_dm_wdata,
  input  logic [63:0] i_riscv_lsu_dm_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LD_HI    = 3'd1,
    ST_ST_RD_HI = 3'd2,
    ST_ST_WR_LO = 3'd3,
    ST_ST_WR_HI = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] lo_q, lo_d;
  logic [63:0] hi_q, hi_d;

  logic [2:0]   off_s;
  logic [3:0]   nbytes_s;
  logic         mis_s;
  logic         cross_s;
  logic [63:0]  base_s;
  logic [63:0]  base_hi_s;
  logic [7:0]   bmask_s;
  logic [15:0]  mask_s;
  logic [127:0] ins_s;
  logic [127:0] ld_src_s;
  logic [127:0] ld_shift_s;

  logic        stall_s, rvalid_s, misaligned_s, wen_s;
  logic [1:0]  sel_s;
  logic [63:0] dm_addr_s, dm_wdata_s, rdata_s;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                         input logic uns);
    logic [63:0] r;
    case (sz)
      2'b00:   r = uns ? {56'd0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
      2'b01:   r = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'b10:   r = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v, input logic [63:0] new_v,
                                              input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = m[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  // Address decode: offset, size, misalignment and doubleword crossing.
  always_comb begin
    off_s     = i_riscv_lsu_addr[2:0];
    nbytes_s  = 4'd1 << i_riscv_lsu_size;
    base_s    = {i_riscv_lsu_addr[63:3], 3'b000};
    base_hi_s = base_s + 64'd8;
    case (i_riscv_lsu_size)
      2'b00:   begin mis_s = 1'b0;                         bmask_s = 8'h01; end
      2'b01:   begin mis_s = i_riscv_lsu_addr[0];          bmask_s = 8'h03; end
      2'b10:   begin mis_s = |i_riscv_lsu_addr[1:0];       bmask_s = 8'h0F; end
      default: begin mis_s = |i_riscv_lsu_addr[2:0];       bmask_s = 8'hFF; end
    endcase
    cross_s    = ({1'b0, off_s} + nbytes_s) > 4'd8;
    mask_s     = {8'd0, bmask_s} << off_s;
    ins_s      = {64'd0, i_riscv_lsu_wdata} << {off_s, 3'b000};
    ld_src_s   = (state_q == ST_LD_HI) ? {i_riscv_lsu_dm_rdata, lo_q}
                                       : {64'd0, i_riscv_lsu_dm_rdata};
    ld_shift_s = ld_src_s >> {off_s, 3'b000};
  end

  // Next-state and data-memory request generation.
  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    stall_s      = 1'b0;
    rvalid_s     = 1'b0;
    misaligned_s = 1'b0;
    wen_s        = 1'b0;
    sel_s        = 2'b00;
    dm_addr_s    = 64'd0;
    dm_wdata_s   = 64'd0;
    rdata_s      = 64'd0;
    case (state_q)
      ST_IDLE: begin
        if (!i_riscv_lsu_req) begin
          state_d = ST_IDLE;
        end else if (mis_s && !MISALIGN_EN) begin
          misaligned_s = 1'b1;
        end else if (!i_riscv_lsu_we) begin
          dm_addr_s = base_s;
          sel_s     = 2'b11;
          if (cross_s) begin
            lo_d    = i_riscv_lsu_dm_rdata;
            stall_s = 1'b1;
            state_d = ST_LD_HI;
          end else begin
            rdata_s  = extend(ld_shift_s[63:0], i_riscv_lsu_size, i_riscv_lsu_unsigned);
            rvalid_s = 1'b1;
          end
        end else if (!mis_s) begin
          dm_addr_s  = i_riscv_lsu_addr;
          sel_s      = i_riscv_lsu_size;
          dm_wdata_s = i_riscv_lsu_wdata;
          wen_s      = 1'b1;
        end else begin
          dm_addr_s = base_s;
          sel_s     = 2'b11;
          lo_d      = i_riscv_lsu_dm_rdata;
          stall_s   = 1'b1;
          state_d   = cross_s ? ST_ST_RD_HI : ST_ST_WR_LO;
        end
      end
      ST_LD_HI: begin
        dm_addr_s = base_hi_s;
        sel_s     = 2'b11;
        rdata_s   = extend(ld_shift_s[63:0], i_riscv_lsu_size, i_riscv_lsu_unsigned);
        rvalid_s  = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_ST_RD_HI: begin
        dm_addr_s = base_hi_s;
        sel_s     = 2'b11;
        hi_d      = i_riscv_lsu_dm_rdata;
        stall_s   = 1'b1;
        state_d   = ST_ST_WR_LO;
      end
      ST_ST_WR_LO: begin
        dm_addr_s  = base_s;
        sel_s      = 2'b11;
        wen_s      = 1'b1;
        dm_wdata_s = merge_bytes(lo_q, ins_s[63:0], mask_s[7:0]);
        if (cross_s) begin
          stall_s = 1'b1;
          state_d = ST_ST_WR_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ST_WR_HI: begin
        dm_addr_s  = base_hi_s;
        sel_s      = 2'b11;
        wen_s      = 1'b1;
        dm_wdata_s = merge_bytes(hi_q, ins_s[127:64], mask_s[15:8]);
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and holding registers.
  always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst_n) begin
    if (!i_riscv_lsu_rst_n) begin
      state_q <= ST_IDLE;
      lo_q    <= 64'd0;
      hi_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Outputs are gated by reset so an in-flight store cannot write while reset is held.
  assign o_riscv_lsu_stall      = i_riscv_lsu_rst_n & stall_s;
  assign o_riscv_lsu_rvalid     = i_riscv_lsu_rst_n & rvalid_s;
  assign o_riscv_lsu_misaligned = i_riscv_lsu_rst_n & misaligned_s;
  assign o_riscv_lsu_dm_wen     = i_riscv_lsu_rst_n & wen_s;
  assign o_riscv_lsu_dm_sel     = i_riscv_lsu_rst_n ? sel_s      : 2'b00;
  assign o_riscv_lsu_dm_addr    = i_riscv_lsu_rst_n ? dm_addr_s  : 64'd0;
  assign o_riscv_lsu_dm_wdata   = i_riscv_lsu_rst_n ? dm_wdata_s : 64'd0;
  assign o_riscv_lsu_rdata      = i_riscv_lsu_rst_n ? rdata_s    : 64'd0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a small doubleword memory stands in for riscv_dm,
// and a second instance with MISALIGN_EN=0 shares the request inputs.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [63:0] addr, wdata;

  logic        s0, rv0, mis0, wen0;
  logic [1:0]  sel0;
  logic [63:0] a0, wd0, rd0, dmr0;
  logic        s1, rv1, mis1, wen1;
  logic [1:0]  sel1;
  logic [63:0] a1, wd1, rd1;
  logic [63:0] dmr1 = 64'd0;

  logic [63:0] mem [0:7];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx = 3'd0;
  logic [63:0] pre_val = 64'd0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  riscv_lsu #(.MISALIGN_EN(1'b1)) u0 (
    .i_riscv_lsu_clk(clk), .i_riscv_lsu_rst_n(rst_n), .i_riscv_lsu_req(req),
    .i_riscv_lsu_we(we), .i_riscv_lsu_size(size), .i_riscv_lsu_unsigned(uns),
    .i_riscv_lsu_addr(addr), .i_riscv_lsu_wdata(wdata), .o_riscv_lsu_stall(s0),
    .o_riscv_lsu_rdata(rd0), .o_riscv_lsu_rvalid(rv0), .o_riscv_lsu_misaligned(mis0),
    .o_riscv_lsu_dm_wen(wen0), .o_riscv_lsu_dm_sel(sel0), .o_riscv_lsu_dm_addr(a0),
    .o_riscv_lsu_dm_wdata(wd0), .i_riscv_lsu_dm_rdata(dmr0));

  riscv_lsu #(.MISALIGN_EN(1'b0)) u1 (
    .i_riscv_lsu_clk(clk), .i_riscv_lsu_rst_n(rst_n), .i_riscv_lsu_req(req),
    .i_riscv_lsu_we(we), .i_riscv_lsu_size(size), .i_riscv_lsu_unsigned(uns),
    .i_riscv_lsu_addr(addr), .i_riscv_lsu_wdata(wdata), .o_riscv_lsu_stall(s1),
    .o_riscv_lsu_rdata(rd1), .o_riscv_lsu_rvalid(rv1), .o_riscv_lsu_misaligned(mis1),
    .o_riscv_lsu_dm_wen(wen1), .o_riscv_lsu_dm_sel(sel1), .o_riscv_lsu_dm_addr(a1),
    .o_riscv_lsu_dm_wdata(wd1), .i_riscv_lsu_dm_rdata(dmr1));

  function automatic logic [63:0] wr_merge(input logic [63:0] old_v, input logic [2:0] off,
                                           input logic [1:0] sel, input logic [63:0] wd);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) begin
      if (b < (1 << sel) && (int'(off) + b) < 8) r[8*(int'(off)+b) +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  assign dmr0 = mem[a0[5:3]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (wen0) mem[a0[5:3]] <= wr_merge(mem[a0[5:3]], a0[2:0], sel0, wd0);
  end

  task automatic set_req(input logic r, input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] d);
    req = r; we = w; size = sz; uns = u; addr = a; wdata = d;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [63:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic preload_std();
    preload(3'd0, 64'h8877665544332211);
    preload(3'd1, 64'hFFEEDDCCBBAA9988);
  endtask

  task automatic test_reset();
    set_req(1'b1, 1'b1, 2'd3, 1'b0, 64'h10, 64'hFFFF);
    #1;
    total++;
    if ({s0, rv0, mis0, wen0, sel0, a0, wd0, rd0} !== '0)
      $display("FAIL reset_u0: outputs not zero, wen=%0b addr=%h", wen0, a0);
    else passed++;
    total++;
    if ({s1, rv1, mis1, wen1, sel1, a1, wd1, rd1} !== '0)
      $display("FAIL reset_u1: outputs not zero, wen=%0b addr=%h", wen1, a1);
    else passed++;
    set_req(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({s0, rv0, mis0, wen0, sel0, a0, wd0, rd0} !== '0)
      $display("FAIL idle_noreq: outputs not zero, stall=%0b addr=%h", s0, a0);
    else passed++;
  endtask

  task automatic test_load_aligned();
    @(negedge clk);
    set_req(1'b1, 1'b0, 2'd1, 1'b1, 64'h2, 64'd0);
    #1;
    total++;
    if (rv0 !== 1'b1 || s0 !== 1'b0 || rd0 !== 64'h0000000000004433 || a0 !== 64'h0 || sel0 !== 2'b11)
      $display("FAIL ld_half_u: rvalid=%0b stall=%0b rdata=%h addr=%h, expected 1 0 0000000000004433 0", rv0, s0, rd0, a0);
    else passed++;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_load_ext();
    logic [63:0] a_v [4] = '{64'hF, 64'h9, 64'h4, 64'h0};
    logic [1:0]  z_v [4] = '{2'd0, 2'd0, 2'd2, 2'd1};
    logic        u_v [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] e_v [4] = '{64'hFFFFFFFFFFFFFFFF, 64'h99, 64'hFFFFFFFF88776655, 64'h2211};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(1'b1, 1'b0, z_v[i], u_v[i], a_v[i], 64'd0);
      #1;
      total++;
      if (rv0 !== 1'b1 || s0 !== 1'b0 || rd0 !== e_v[i])
        $display("FAIL ld_ext%0d: rvalid=%0b stall=%0b rdata=%h expected %h", i, rv0, s0, rd0, e_v[i]);
      else passed++;
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_load_cross();
    @(negedge clk);
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 64'h6, 64'd0);
    #1;
    total++;
    if (s0 !== 1'b1 || rv0 !== 1'b0 || a0 !== 64'h0)
      $display("FAIL ld_cross_c0: stall=%0b rvalid=%0b addr=%h expected 1 0 0", s0, rv0, a0);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (s0 !== 1'b0 || rv0 !== 1'b1 || a0 !== 64'h8 || rd0 !== 64'hFFFFFFFF99888877)
      $display("FAIL ld_cross_c1: stall=%0b rvalid=%0b addr=%h rdata=%h expected 0 1 8 FFFFFFFF99888877", s0, rv0, a0, rd0);
    else passed++;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic run_store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d,
                           input int exp_stall, input string name);
    int cyc = 0;
    bit done = 1'b0;
    @(negedge clk);
    set_req(1'b1, 1'b1, sz, 1'b0, a, d);
    for (int i = 0; i < 8; i++) begin
      if (!done) begin
        #1;
        if (s0) begin
          cyc++;
          @(negedge clk);
        end else done = 1'b1;
      end
    end
    total++;
    if (!done || cyc != exp_stall)
      $display("FAIL %s_stall: stall cycles=%0d (finished=%0b) expected %0d", name, cyc, done, exp_stall);
    else passed++;
    @(negedge clk);
    req = 1'b0;
    #1;
  endtask

  task automatic test_store_cross();
    run_store(2'd1, 64'h7, 64'hABCD, 3, "st_cross");
    total++;
    if (mem[0] !== 64'hCD77665544332211 || mem[1] !== 64'hFFEEDDCCBBAA99AB)
      $display("FAIL st_cross_mem: dw0=%h dw8=%h expected CD77665544332211 FFEEDDCCBBAA99AB", mem[0], mem[1]);
    else passed++;
    @(negedge clk);
    set_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'd0);
    #1;
    total++;
    if (rv0 !== 1'b1 || rd0 !== 64'hCD77665544332211)
      $display("FAIL st_cross_reload: rvalid=%0b rdata=%h expected 1 CD77665544332211", rv0, rd0);
    else passed++;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_store_mis();
    run_store(2'd2, 64'h2, 64'hDEADBEEF, 1, "st_mis");
    total++;
    if (mem[0] !== 64'h8877DEADBEEF2211 || mem[1] !== 64'hFFEEDDCCBBAA9988)
      $display("FAIL st_mis_mem: dw0=%h dw8=%h expected 8877DEADBEEF2211 FFEEDDCCBBAA9988", mem[0], mem[1]);
    else passed++;
  endtask

  task automatic test_store_aligned();
    @(negedge clk);
    set_req(1'b1, 1'b1, 2'd0, 1'b0, 64'h9, 64'h5A);
    #1;
    total++;
    if (wen0 !== 1'b1 || s0 !== 1'b0 || sel0 !== 2'd0 || a0 !== 64'h9 || wd0 !== 64'h5A)
      $display("FAIL st_byte: wen=%0b stall=%0b sel=%0d addr=%h wdata=%h expected 1 0 0 9 5a", wen0, s0, sel0, a0, wd0);
    else passed++;
    @(negedge clk);
    req = 1'b0;
    #1;
    total++;
    if (mem[1] !== 64'hFFEEDDCCBBAA5A88)
      $display("FAIL st_byte_mem: dw8=%h expected FFEEDDCCBBAA5A88", mem[1]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(1'b1, 1'b1, 2'd2, 1'b0, 64'h6, 64'h11223344);
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (wen0 !== 1'b1 || a0 !== 64'h0 || s0 !== 1'b1)
      $display("FAIL rst_mid_wrlo: wen=%0b addr=%h stall=%0b expected 1 0 1", wen0, a0, s0);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({s0, rv0, mis0, wen0, sel0, a0, wd0, rd0} !== '0)
      $display("FAIL rst_mid_out: outputs not zero, wen=%0b stall=%0b addr=%h", wen0, s0, a0);
    else passed++;
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (mem[0] !== 64'h8877665544332211 || mem[1] !== 64'hFFEEDDCCBBAA9988)
      $display("FAIL rst_mid_mem: dw0=%h dw8=%h expected unchanged", mem[0], mem[1]);
    else passed++;
    @(negedge clk);
    set_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'd0);
    #1;
    total++;
    if (rv0 !== 1'b1 || s0 !== 1'b0 || a0 !== 64'h8 || rd0 !== 64'hFFEEDDCCBBAA9988)
      $display("FAIL rst_mid_idle: rvalid=%0b stall=%0b addr=%h rdata=%h expected 1 0 8 FFEEDDCCBBAA9988", rv0, s0, a0, rd0);
    else passed++;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_misalign_dis();
    @(negedge clk);
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 64'h3, 64'd0);
    #1;
    total++;
    if (mis1 !== 1'b1 || rv1 !== 1'b0 || wen1 !== 1'b0 || s1 !== 1'b0)
      $display("FAIL nomis_ld: misaligned=%0b rvalid=%0b wen=%0b stall=%0b expected 1 0 0 0", mis1, rv1, wen1, s1);
    else passed++;
    total++;
    if (mis0 !== 1'b0)
      $display("FAIL mis_flag_en: misaligned=%0b expected 0", mis0);
    else passed++;
    @(negedge clk);
    set_req(1'b1, 1'b1, 2'd3, 1'b0, 64'h10, 64'h0123456789ABCDEF);
    #1;
    total++;
    if (wen1 !== 1'b1 || mis1 !== 1'b0 || s1 !== 1'b0 || sel1 !== 2'd3 || a1 !== 64'h10 || wd1 !== 64'h0123456789ABCDEF)
      $display("FAIL nomis_st: wen=%0b mis=%0b stall=%0b sel=%0d addr=%h wdata=%h", wen1, mis1, s1, sel1, a1, wd1);
    else passed++;
    @(negedge clk);
    req = 1'b0;
    #1;
    total++;
    if (mem[2] !== 64'h0123456789ABCDEF)
      $display("FAIL st_dw_mem: dw10=%h expected 0123456789ABCDEF", mem[2]);
    else passed++;
  endtask

  task automatic test_wrap();
    preload(3'd7, 64'h0011223344556677);
    @(negedge clk);
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 64'hFFFFFFFFFFFFFFFE, 64'd0);
    #1;
    total++;
    if (s0 !== 1'b1 || a0 !== 64'hFFFFFFFFFFFFFFF8)
      $display("FAIL wrap_c0: stall=%0b addr=%h expected 1 FFFFFFFFFFFFFFF8", s0, a0);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (rv0 !== 1'b1 || a0 !== 64'h0 || rd0 !== 64'h0000000022110011)
      $display("FAIL wrap_c1: rvalid=%0b addr=%h rdata=%h expected 1 0 0000000022110011", rv0, a0, rd0);
    else passed++;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    set_req(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    test_reset();
    preload_std();
    test_load_aligned();
    test_load_ext();
    test_load_cross();
    test_store_cross();
    preload_std();
    test_store_mis();
    test_store_aligned();
    preload_std();
    test_reset_mid();
    test_misalign_dis();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
